// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline boundary for the P5 MIPS core.
// A two-entry skid buffer (main + skid) sits between fetch and decode.
// Decode always sees the main entry. The skid entry catches the one extra
// instruction that fetch may launch in the cycle decode stalls. This lets
// if_ready come straight from a flop, with no combinational path from id_ready.
// The buffer also handles flush on redirect, drives a NOP when empty, computes
// PC+8 for link instructions and counts decode-stall cycles.

module if_id_skid_reg #(
    parameter logic [31:0] RESET_PC  = 32'h0000_3000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    output logic        if_ready,
    input  logic        flush,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc8,
    output logic [1:0]  occupancy,
    output logic [31:0] stall_cnt
);

    // Link-address helper: return address of a jump-and-link (delay slot skipped).
    function automatic logic [31:0] pc_plus8(input logic [31:0] pc);
        return pc + 32'd8;
    endfunction

    // Entry storage
    logic        main_v_r;
    logic [31:0] main_pc_r;
    logic [31:0] main_instr_r;
    logic        skid_v_r;
    logic [31:0] skid_pc_r;
    logic [31:0] skid_instr_r;
    logic [31:0] stall_cnt_r;

    // Next-state values
    logic        main_v_s;
    logic [31:0] main_pc_s;
    logic [31:0] main_instr_s;
    logic        skid_v_s;
    logic [31:0] skid_pc_s;
    logic [31:0] skid_instr_s;

    // Handshake terms
    logic        if_ready_s;
    logic        acc_s;
    logic        deq_s;
    logic        stall_s;

    // if_ready is the inverted skid flag, so it is registered.
    assign if_ready_s = ~skid_v_r;
    assign acc_s      = if_valid & if_ready_s & ~flush;
    assign deq_s      = main_v_r & id_ready;
    assign stall_s    = main_v_r & ~id_ready;

    // Next-state selection for the main and skid entries, in priority order
    always_comb begin
        main_v_s     = main_v_r;
        main_pc_s    = main_pc_r;
        main_instr_s = main_instr_r;
        skid_v_s     = skid_v_r;
        skid_pc_s    = skid_pc_r;
        skid_instr_s = skid_instr_r;

        if (flush) begin
            // Drop everything. The stale PC/instr stay, hidden behind main_v=0.
            main_v_s = 1'b0;
            skid_v_s = 1'b0;
        end else if (!main_v_r) begin
            // Empty buffer: the skid is empty too, so a new entry goes to main.
            if (acc_s) begin
                main_v_s     = 1'b1;
                main_pc_s    = if_pc;
                main_instr_s = if_instr;
            end else begin
                main_v_s = 1'b0;
            end
        end else begin
            case ({deq_s, skid_v_r})
                2'b11: begin
                    // Head consumed, and the older skid entry moves up.
                    main_v_s     = 1'b1;
                    main_pc_s    = skid_pc_r;
                    main_instr_s = skid_instr_r;
                    skid_v_s     = 1'b0;
                end
                2'b10: begin
                    // Head consumed and nothing waits in skid: refill directly.
                    if (acc_s) begin
                        main_v_s     = 1'b1;
                        main_pc_s    = if_pc;
                        main_instr_s = if_instr;
                    end else begin
                        main_v_s = 1'b0;
                    end
                end
                2'b00: begin
                    // Decode stalled: park the in-flight fetch in the skid slot.
                    if (acc_s) begin
                        skid_v_s     = 1'b1;
                        skid_pc_s    = if_pc;
                        skid_instr_s = if_instr;
                    end else begin
                        skid_v_s = 1'b0;
                    end
                end
                2'b01: begin
                    // Both slots full and decode stalled: hold.
                    main_v_s = 1'b1;
                    skid_v_s = 1'b1;
                end
                default: begin
                    main_v_s = 1'b0;
                    skid_v_s = 1'b0;
                end
            endcase
        end
    end

    // Entry registers; synchronous reset restores the boot PC and a NOP
    always_ff @(posedge clk) begin
        if (reset) begin
            main_v_r     <= 1'b0;
            main_pc_r    <= RESET_PC;
            main_instr_r <= NOP_INSTR;
            skid_v_r     <= 1'b0;
            skid_pc_r    <= 32'h0000_0000;
            skid_instr_r <= 32'h0000_0000;
        end else begin
            main_v_r     <= main_v_s;
            main_pc_r    <= main_pc_s;
            main_instr_r <= main_instr_s;
            skid_v_r     <= skid_v_s;
            skid_pc_r    <= skid_pc_s;
            skid_instr_r <= skid_instr_s;
        end
    end

    // Decode-stall counter. It counts flush cycles too and wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_r <= 32'h0000_0000;
        end else if (stall_s) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    // Output drive: flops directly, except the NOP mux and the link adder.
    assign if_ready  = if_ready_s;
    assign id_valid  = main_v_r;
    assign id_pc     = main_pc_r;
    assign id_instr  = main_v_r ? main_instr_r : NOP_INSTR;
    assign id_pc8    = pc_plus8(main_pc_r);
    assign occupancy = {1'b0, main_v_r} + {1'b0, skid_v_r};
    assign stall_cnt = stall_cnt_r;

    if_id_skid_reg_chk u_chk (
        .clk       (clk),
        .reset     (reset),
        .main_v    (main_v_r),
        .skid_v    (skid_v_r),
        .if_ready  (if_ready_s),
        .occupancy (occupancy)
    );

endmodule

// Structural invariants of the skid buffer
module if_id_skid_reg_chk (
    input logic       clk,
    input logic       reset,
    input logic       main_v,
    input logic       skid_v,
    input logic       if_ready,
    input logic [1:0] occupancy
);

    // Skid may only hold an entry younger than a valid main entry
    always @(posedge clk) begin
        if (!reset) begin
            a_skid_implies_main: assert (!skid_v || main_v);
            a_occ_range:         assert (occupancy != 2'd3);
            a_ready_from_skid:   assert (if_ready == !skid_v);
        end
    end

endmodule

// File: tb/tb_if_id_skid_reg.sv
// Directed bench for if_id_skid_reg. A vector table checks reset, streaming,
// stall, flush, reset mid-operation and PC+8 wrap. A scoreboarded sequence then
// checks ordering under an irregular decode-ready pattern.

module tb_if_id_skid_reg;

    logic        clk;
    logic        reset;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_ready;
    logic        flush;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_instr;
    logic [31:0] id_pc8;
    logic [1:0]  occupancy;
    logic [31:0] stall_cnt;

    int tests_run = 0;
    int tests_failed = 0;

    if_id_skid_reg dut (
        .clk       (clk),
        .reset     (reset),
        .if_valid  (if_valid),
        .if_pc     (if_pc),
        .if_instr  (if_instr),
        .if_ready  (if_ready),
        .flush     (flush),
        .id_ready  (id_ready),
        .id_valid  (id_valid),
        .id_pc     (id_pc),
        .id_instr  (id_instr),
        .id_pc8    (id_pc8),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        iv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fl;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_ready;
        logic [1:0]  e_occ;
        logic [31:0] e_stall;
    } vec_t;

    vec_t vecs[$];

    task automatic addv(input logic rst, input logic iv, input logic [31:0] pc,
                        input logic [31:0] instr, input logic fl, input logic rdy,
                        input logic ev, input logic [31:0] epc, input logic [31:0] ein,
                        input logic erd, input logic [1:0] eocc, input logic [31:0] esc);
        vec_t v;
        v.rst = rst; v.iv = iv; v.pc = pc; v.instr = instr; v.fl = fl; v.rdy = rdy;
        v.e_valid = ev; v.e_pc = epc; v.e_instr = ein; v.e_ready = erd;
        v.e_occ = eocc; v.e_stall = esc;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int row, input logic [31:0] act,
                         input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    localparam logic [31:0] IA = 32'h3401_0001;
    localparam logic [31:0] IB = 32'h3402_0002;
    localparam logic [31:0] IC = 32'h0022_1821;
    localparam logic [31:0] ID = 32'h1111_1111;
    localparam logic [31:0] IE = 32'h2222_2222;
    localparam logic [31:0] IF = 32'h3333_3333;
    localparam logic [31:0] IW = 32'h2442_0001;

    initial begin
        logic [31:0] sb_q[$];
        int sent;
        int rcvd;
        logic [31:0] exp_pc;

        // rst iv  pc             instr  fl   rdy  | ev  pc             instr  ird  occ   stall
        // Reset then idle
        addv(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0,  1'b0, 32'h0000_3000, 32'h0, 1'b1, 2'd0, 32'd0);
        addv(1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0,  1'b0, 32'h0000_3000, 32'h0, 1'b1, 2'd0, 32'd0);
        addv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1,  1'b0, 32'h0000_3000, 32'h0, 1'b1, 2'd0, 32'd0);
        // Streaming at full rate
        addv(1'b0, 1'b1, 32'h0000_3000, IA, 1'b0, 1'b1,  1'b1, 32'h0000_3000, IA, 1'b1, 2'd1, 32'd0);
        addv(1'b0, 1'b1, 32'h0000_3004, IB, 1'b0, 1'b1,  1'b1, 32'h0000_3004, IB, 1'b1, 2'd1, 32'd0);
        addv(1'b0, 1'b1, 32'h0000_3008, IC, 1'b0, 1'b1,  1'b1, 32'h0000_3008, IC, 1'b1, 2'd1, 32'd0);
        addv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1,  1'b0, 32'h0000_3008, 32'h0, 1'b1, 2'd0, 32'd0);
        // Decode stall for three cycles, then release
        addv(1'b0, 1'b1, 32'h0000_3000, IA, 1'b0, 1'b1,  1'b1, 32'h0000_3000, IA, 1'b1, 2'd1, 32'd0);
        addv(1'b0, 1'b1, 32'h0000_3004, IB, 1'b0, 1'b0,  1'b1, 32'h0000_3000, IA, 1'b0, 2'd2, 32'd1);
        addv(1'b0, 1'b1, 32'h0000_3008, IC, 1'b0, 1'b0,  1'b1, 32'h0000_3000, IA, 1'b0, 2'd2, 32'd2);
        addv(1'b0, 1'b1, 32'h0000_3008, IC, 1'b0, 1'b0,  1'b1, 32'h0000_3000, IA, 1'b0, 2'd2, 32'd3);
        addv(1'b0, 1'b1, 32'h0000_3008, IC, 1'b0, 1'b1,  1'b1, 32'h0000_3004, IB, 1'b1, 2'd1, 32'd3);
        addv(1'b0, 1'b1, 32'h0000_3008, IC, 1'b0, 1'b1,  1'b1, 32'h0000_3008, IC, 1'b1, 2'd1, 32'd3);
        addv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1,  1'b0, 32'h0000_3008, 32'h0, 1'b1, 2'd0, 32'd3);
        // Flush with full buffer while 0x3010 is offered
        addv(1'b0, 1'b1, 32'h0000_3000, IA, 1'b0, 1'b1,  1'b1, 32'h0000_3000, IA, 1'b1, 2'd1, 32'd3);
        addv(1'b0, 1'b1, 32'h0000_3004, IB, 1'b0, 1'b0,  1'b1, 32'h0000_3000, IA, 1'b0, 2'd2, 32'd4);
        addv(1'b0, 1'b1, 32'h0000_3010, ID, 1'b1, 1'b0,  1'b0, 32'h0000_3000, 32'h0, 1'b1, 2'd0, 32'd5);
        addv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1,  1'b0, 32'h0000_3000, 32'h0, 1'b1, 2'd0, 32'd5);
        // Reset mid-operation with full buffer and decode stalled
        addv(1'b0, 1'b1, 32'h0000_3020, IE, 1'b0, 1'b0,  1'b1, 32'h0000_3020, IE, 1'b1, 2'd1, 32'd5);
        addv(1'b0, 1'b1, 32'h0000_3024, IF, 1'b0, 1'b0,  1'b1, 32'h0000_3020, IE, 1'b0, 2'd2, 32'd6);
        addv(1'b1, 1'b1, 32'h0000_3028, IF, 1'b0, 1'b0,  1'b0, 32'h0000_3000, 32'h0, 1'b1, 2'd0, 32'd0);
        addv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1,  1'b0, 32'h0000_3000, 32'h0, 1'b1, 2'd0, 32'd0);
        // PC+8 wrap, then a flush into an empty buffer drops the offered entry
        addv(1'b0, 1'b1, 32'hFFFF_FFFC, IW, 1'b0, 1'b1,  1'b1, 32'hFFFF_FFFC, IW, 1'b1, 2'd1, 32'd0);
        addv(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1,  1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 2'd0, 32'd0);
        addv(1'b0, 1'b1, 32'h0000_3040, IA, 1'b1, 1'b1,  1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 2'd0, 32'd0);

        for (int i = 0; i < vecs.size(); i++) begin
            reset    = vecs[i].rst;
            if_valid = vecs[i].iv;
            if_pc    = vecs[i].pc;
            if_instr = vecs[i].instr;
            flush    = vecs[i].fl;
            id_ready = vecs[i].rdy;
            @(posedge clk);
            #1;
            check("id_valid",  i, {31'd0, id_valid},  {31'd0, vecs[i].e_valid});
            check("id_pc",     i, id_pc,              vecs[i].e_pc);
            check("id_instr",  i, id_instr,           vecs[i].e_instr);
            check("id_pc8",    i, id_pc8,             vecs[i].e_pc + 32'd8);
            check("if_ready",  i, {31'd0, if_ready},  {31'd0, vecs[i].e_ready});
            check("occupancy", i, {30'd0, occupancy}, {30'd0, vecs[i].e_occ});
            check("stall_cnt", i, stall_cnt,          vecs[i].e_stall);
        end

        // Explicit wrap check on the link address after the 0xFFFF_FFFC row
        check("pc8_wrap", 99, id_pc8, 32'h0000_0004);

        // Irregular decode-ready pattern: every accepted entry must emerge once, in order
        sent = 0;
        rcvd = 0;
        flush = 1'b0;
        reset = 1'b0;
        for (int cyc = 0; cyc < 80 && rcvd < 8; cyc++) begin
            if_valid = (sent < 8);
            if_pc    = 32'h0000_4000 + 32'(sent) * 32'd4;
            if_instr = if_pc ^ 32'hA5A5_0000;
            id_ready = ((cyc % 3) != 1);
            if (id_valid && id_ready) begin
                exp_pc = (sb_q.size() > 0) ? sb_q.pop_front() : 32'hDEAD_BEEF;
                check("sb_pc",    rcvd, id_pc,    exp_pc);
                check("sb_instr", rcvd, id_instr, exp_pc ^ 32'hA5A5_0000);
                rcvd++;
            end
            if (if_valid && if_ready) begin
                sb_q.push_back(if_pc);
                sent++;
            end
            @(posedge clk);
            #1;
        end
        check("sb_count", 0, 32'(rcvd), 32'd8);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
